psk_link_ctrl: RTL and testbench
================================

Name: psk_link_ctrl

Overview:
- Runtime link sequencer for the PSK transceiver. Replaces the fixed configuration constants for MODE_CTRL, DELAY_CNT, GARDNER_SHIFT and FEEDBACK_SHIFT.
- Sequences mode changes safely: drains the Tx frame, applies the new config, flushes Rx, then supervises receiver lock with timeout and retry.
- Sits beside Tx and Rx_wrapper in the 1.024 MHz domain. Rx_valid arrives already synchronised.

Parameters:
- DEFAULT_MODE, 4, MODE_CTRL value after reset
- DEFAULT_DELAY, 8, DELAY_CNT value (static)
- DEFAULT_GARDNER, 3, GARDNER_SHIFT value (static)
- DEFAULT_FEEDBACK, 0, FEEDBACK_SHIFT value (static)
- FLUSH_CYCLES, 16, rx_flush assertion length in cycles
- LOCK_HOLD, 32, consecutive rx_valid=1 cycles required to declare lock
- LOCK_TIMEOUT, 4096, ACQUIRE cycles before a retry
- LOSS_CYCLES, 64, consecutive rx_valid=0 cycles in LOCKED that declare loss
- DRAIN_TIMEOUT, 1024, maximum cycles spent waiting for tx_data_tlast
- MAX_RETRY, 3, ACQUIRE attempts before FAIL

Ports:
- clk_1M024  in  1  system clock, 1.024 MHz
- rst_n_1M024  in  1  asynchronous, active-low reset
- mode_req  in  4  requested MODE_CTRL value
- mode_req_valid  in  1  request valid
- mode_req_ready  out  1  request accepted when valid & ready
- tx_data_tvalid  in  1  Tx frame stream valid
- tx_data_tlast  in  1  Tx frame last byte
- rx_valid  in  1  Rx_valid from Rx_wrapper
- MODE_CTRL  out  4  active mode
- DELAY_CNT  out  8  Tx delay config
- GARDNER_SHIFT  out  4  timing-loop shift
- FEEDBACK_SHIFT  out  4  carrier-loop shift
- tx_enable  out  1  Tx frame gate
- rx_flush  out  1  Rx clear/hold request
- link_up  out  1  receiver locked
- link_fail  out  1  retries exhausted
- state_dbg  out  3  encoded state (ILA)

Behaviour:
- State encoding: FLUSH=0, ACQUIRE=1, LOCKED=2, DRAIN=3, APPLY=4, FAIL=5.
- Reset (async assert, sync deassert inside block):
  - state=FLUSH, MODE_CTRL=DEFAULT_MODE, DELAY/GARDNER/FEEDBACK = their defaults
  - tx_enable=0, rx_flush=1, link_up=0, link_fail=0, mode_req_ready=0
  - all counters = 0
- All outputs are registered.
- FLUSH:
  - rx_flush=1, tx_enable=1; exits after exactly FLUSH_CYCLES cycles to ACQUIRE.
  - lock counter cleared; retry count kept.
- ACQUIRE:
  - rx_flush=0; lock_cnt increments on rx_valid=1 and clears on rx_valid=0.
  - lock_cnt reaching LOCK_HOLD → LOCKED, link_up=1 next cycle, retry count cleared.
  - timeout counter reaching LOCK_TIMEOUT → retry+1, then FLUSH if retry<MAX_RETRY, else FAIL.
  - Lock and timeout in the same cycle: lock wins.
- LOCKED:
  - link_up=1.
  - rx_valid low for LOSS_CYCLES consecutive cycles → link_up=0, FLUSH, retry count reset.
- FAIL:
  - link_fail=1, tx_enable=1, rx_flush=0.
  - Leaves only on an accepted request, which clears link_fail.
- mode_req_ready:
  - =1 in ACQUIRE, LOCKED, FAIL; =0 elsewhere.
  - Transfer on valid&ready; ready drops the following cycle.
  - A request equal to the current MODE_CTRL in LOCKED is accepted and consumed with no state change.
  - Any other accepted request latches mode_req into pending_mode → DRAIN.
  - A request and a loss/timeout event in the same cycle: request wins.
- DRAIN:
  - tx_enable stays 1 until a cycle with tx_data_tvalid&tx_data_tlast; tx_enable=0 from the next cycle.
  - Also exits after DRAIN_TIMEOUT cycles, with tx_enable forced 0.
  - link_up=0 on entry.
  - Exits to APPLY.
- APPLY (1 cycle): MODE_CTRL<=pending_mode, retry=0, → FLUSH. tx_enable re-asserts on FLUSH entry.
- Counters saturate and never wrap. Widths are $clog2 of the relevant parameter +1.
- Mid-operation reset: immediate return to reset values. Any pending request is lost.

Decomposition:
- Shared package psk_ctrl_pkg holds:
  - state enum (values above)
  - default config constants shared with the Tx/Rx configuration
- One sub-module, sat_counter: parameterised width and limit, with inputs clr and inc and output hit.
  - Instantiated for flush, lock, timeout, loss and drain.

Test Plan:
- Reset release, rx_valid=1 continuously → rx_flush high 16 cycles, then link_up=1 at cycle 16+32+1, MODE_CTRL=4, state_dbg=2.
- In LOCKED, request mode 2 with tx_data_tlast 10 cycles later:
  - ready pulses 1 cycle; tx_enable falls the cycle after tlast
  - MODE_CTRL=2 after APPLY; rx_flush 16 cycles; link_up re-asserts.
- rx_valid held 0 → three 4096-cycle timeouts, each followed by a 16-cycle flush; link_fail=1 after the third; new request clears link_fail.
- In LOCKED, rx_valid low 63 cycles then high → link_up stays 1; low 64 cycles → link_up=0, state FLUSH.
- Request with no tlast → tx_enable forced 0 after 1024 cycles, then APPLY.
- Request equal to current mode in LOCKED → accepted, no flush, link_up stays 1. Assert reset mid-DRAIN → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/psk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// psk_ctrl_pkg : link-sequencer state encoding and shared Tx/Rx config defaults
// Revision     : 1.0
// ============================================================================
package psk_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH   = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_APPLY   = 3'd4,
        ST_FAIL    = 3'd5
    } psk_state_e;

    localparam logic [3:0] PSK_DEFAULT_MODE     = 4'd4;
    localparam logic [7:0] PSK_DEFAULT_DELAY    = 8'd8;
    localparam logic [3:0] PSK_DEFAULT_GARDNER  = 4'd3;
    localparam logic [3:0] PSK_DEFAULT_FEEDBACK = 4'd0;

    // States in which a mode request may be taken.
    function automatic logic req_allowed(input psk_state_e s);
        return (s == ST_ACQUIRE) || (s == ST_LOCKED) || (s == ST_FAIL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating event counter; hit flags the cycle the count
//               reaches LIMIT (or any cycle it sits there).
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned WIDTH = $clog2(LIMIT) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = !clr && ((cnt_q == LIM) || (inc && (cnt_q == LIM - 1'b1)));

endmodule
`default_nettype wire

// File: rtl/psk_link_ctrl.sv
`default_nettype none
// ============================================================================
// psk_link_ctrl : runtime PSK link sequencer (drain Tx, apply mode, flush Rx,
//                 supervise lock with timeout/retry).
// Revision      : 1.0
// ============================================================================
module psk_link_ctrl
    import psk_ctrl_pkg::*;
#(
    parameter logic [3:0]  DEFAULT_MODE     = PSK_DEFAULT_MODE,
    parameter logic [7:0]  DEFAULT_DELAY    = PSK_DEFAULT_DELAY,
    parameter logic [3:0]  DEFAULT_GARDNER  = PSK_DEFAULT_GARDNER,
    parameter logic [3:0]  DEFAULT_FEEDBACK = PSK_DEFAULT_FEEDBACK,
    parameter int unsigned FLUSH_CYCLES     = 16,
    parameter int unsigned LOCK_HOLD        = 32,
    parameter int unsigned LOCK_TIMEOUT     = 4096,
    parameter int unsigned LOSS_CYCLES      = 64,
    parameter int unsigned DRAIN_TIMEOUT    = 1024,
    parameter int unsigned MAX_RETRY        = 3
) (
    input  logic       clk_1M024,
    input  logic       rst_n_1M024,
    input  logic [3:0] mode_req,
    input  logic       mode_req_valid,
    output logic       mode_req_ready,
    input  logic       tx_data_tvalid,
    input  logic       tx_data_tlast,
    input  logic       rx_valid,
    output logic [3:0] MODE_CTRL,
    output logic [7:0] DELAY_CNT,
    output logic [3:0] GARDNER_SHIFT,
    output logic [3:0] FEEDBACK_SHIFT,
    output logic       tx_enable,
    output logic       rx_flush,
    output logic       link_up,
    output logic       link_fail,
    output logic [2:0] state_dbg
);

    localparam int unsigned      RETRY_W   = $clog2(MAX_RETRY) + 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic [1:0]         rst_sync_q;
    logic               rst_n_int;
    psk_state_e         state_q, state_d;
    logic [3:0]         mode_q, mode_d;
    logic [3:0]         pending_q, pending_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               ready_q, tx_en_q, rx_flush_q, link_up_q, link_fail_q;
    logic               accept;
    logic               flush_hit, lock_hit, to_hit, loss_hit, drain_hit;
    logic               in_flush, in_acq, in_locked, in_drain;

    // Assert asynchronously, release two clocks after the pin goes high.
    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync_q[1];

    assign in_flush  = (state_q == ST_FLUSH);
    assign in_acq    = (state_q == ST_ACQUIRE);
    assign in_locked = (state_q == ST_LOCKED);
    assign in_drain  = (state_q == ST_DRAIN);

    sat_counter #(.LIMIT(FLUSH_CYCLES)) u_flush_cnt (
        .clk(clk_1M024), .rst_n(rst_n_int),
        .clr(!in_flush), .inc(1'b1), .hit(flush_hit)
    );

    sat_counter #(.LIMIT(LOCK_HOLD)) u_lock_cnt (
        .clk(clk_1M024), .rst_n(rst_n_int),
        .clr(!in_acq || !rx_valid), .inc(rx_valid), .hit(lock_hit)
    );

    sat_counter #(.LIMIT(LOCK_TIMEOUT)) u_timeout_cnt (
        .clk(clk_1M024), .rst_n(rst_n_int),
        .clr(!in_acq), .inc(1'b1), .hit(to_hit)
    );

    sat_counter #(.LIMIT(LOSS_CYCLES)) u_loss_cnt (
        .clk(clk_1M024), .rst_n(rst_n_int),
        .clr(!in_locked || rx_valid), .inc(1'b1), .hit(loss_hit)
    );

    sat_counter #(.LIMIT(DRAIN_TIMEOUT)) u_drain_cnt (
        .clk(clk_1M024), .rst_n(rst_n_int),
        .clr(!in_drain), .inc(1'b1), .hit(drain_hit)
    );

    assign accept    = mode_req_valid && ready_q;
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

    // An accepted request takes priority over lock, timeout and loss events.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        retry_d   = retry_q;
        case (state_q)
            ST_FLUSH: begin
                if (flush_hit) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (accept) begin
                    pending_d = mode_req;
                    state_d   = ST_DRAIN;
                end else if (lock_hit) begin
                    retry_d = '0;
                    state_d = ST_LOCKED;
                end else if (to_hit) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc < RETRY_MAX) ? ST_FLUSH : ST_FAIL;
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    if (mode_req != mode_q) begin
                        pending_d = mode_req;
                        state_d   = ST_DRAIN;
                    end
                end else if (loss_hit) begin
                    retry_d = '0;
                    state_d = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if ((tx_data_tvalid && tx_data_tlast) || drain_hit) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                mode_d  = pending_q;
                retry_d = '0;
                state_d = ST_FLUSH;
            end
            ST_FAIL: begin
                if (accept) begin
                    pending_d = mode_req;
                    state_d   = ST_DRAIN;
                end
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk_1M024 or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= ST_FLUSH;
            mode_q      <= DEFAULT_MODE;
            pending_q   <= DEFAULT_MODE;
            retry_q     <= '0;
            ready_q     <= 1'b0;
            tx_en_q     <= 1'b0;
            rx_flush_q  <= 1'b1;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            retry_q     <= retry_d;
            ready_q     <= req_allowed(state_d) && !accept;
            tx_en_q     <= (state_d != ST_APPLY);
            rx_flush_q  <= (state_d == ST_FLUSH);
            link_up_q   <= (state_d == ST_LOCKED);
            link_fail_q <= (state_d == ST_FAIL);
        end
    end

    assign mode_req_ready = ready_q;
    assign MODE_CTRL      = mode_q;
    assign DELAY_CNT      = DEFAULT_DELAY;
    assign GARDNER_SHIFT  = DEFAULT_GARDNER;
    assign FEEDBACK_SHIFT = DEFAULT_FEEDBACK;
    assign tx_enable      = tx_en_q;
    assign rx_flush       = rx_flush_q;
    assign link_up        = link_up_q;
    assign link_fail      = link_fail_q;
    assign state_dbg      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_psk_link_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_psk_link_ctrl : directed self-checking bench for psk_link_ctrl
// Revision         : 1.0
// ============================================================================
module tb_psk_link_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] mode_req;
    logic       mode_req_valid;
    logic       mode_req_ready;
    logic       tx_data_tvalid;
    logic       tx_data_tlast;
    logic       rx_valid;
    logic [3:0] MODE_CTRL;
    logic [7:0] DELAY_CNT;
    logic [3:0] GARDNER_SHIFT;
    logic [3:0] FEEDBACK_SHIFT;
    logic       tx_enable;
    logic       rx_flush;
    logic       link_up;
    logic       link_fail;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];

    localparam int S_FLUSH = 0, S_ACQ = 1, S_LOCKED = 2, S_DRAIN = 3, S_APPLY = 4, S_FAIL = 5;

    always #5 clk = ~clk;

    psk_link_ctrl dut (
        .clk_1M024      (clk),
        .rst_n_1M024    (rst_n),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_req_ready (mode_req_ready),
        .tx_data_tvalid (tx_data_tvalid),
        .tx_data_tlast  (tx_data_tlast),
        .rx_valid       (rx_valid),
        .MODE_CTRL      (MODE_CTRL),
        .DELAY_CNT      (DELAY_CNT),
        .GARDNER_SHIFT  (GARDNER_SHIFT),
        .FEEDBACK_SHIFT (FEEDBACK_SHIFT),
        .tx_enable      (tx_enable),
        .rx_flush       (rx_flush),
        .link_up        (link_up),
        .link_fail      (link_fail),
        .state_dbg      (state_dbg)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count consecutive samples spent in state s (bounded).
    task automatic count_state(input int s, input int max, output int n);
        n = 0;
        while ((int'(state_dbg) == s) && (n < max)) begin
            n++;
            cyc(1);
        end
    endtask

    // Cycles until link_up rises; an expired bound shows up as a wrong count.
    task automatic wait_link(input int max, output int n);
        n = 0;
        while ((link_up !== 1'b1) && (n < max)) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic sb_pop(input string tag);
        logic [3:0] exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            exp = sb.pop_front();
            check(tag, int'(MODE_CTRL), int'(exp));
        end
    endtask

    task automatic request(input logic [3:0] m);
        mode_req       = m;
        mode_req_valid = 1'b1;
        cyc(1);
        mode_req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n          = 1'b0;
        mode_req       = 4'd0;
        mode_req_valid = 1'b0;
        tx_data_tvalid = 1'b0;
        tx_data_tlast  = 1'b0;
        rx_valid       = 1'b1;
        cyc(3);

        // Reset values
        check("rst_state",    int'(state_dbg), S_FLUSH);
        check("rst_mode",     int'(MODE_CTRL), 4);
        check("rst_delay",    int'(DELAY_CNT), 8);
        check("rst_gardner",  int'(GARDNER_SHIFT), 3);
        check("rst_feedback", int'(FEEDBACK_SHIFT), 0);
        check("rst_txen",     int'(tx_enable), 0);
        check("rst_flush",    int'(rx_flush), 1);
        check("rst_linkup",   int'(link_up), 0);
        check("rst_fail",     int'(link_fail), 0);
        check("rst_ready",    int'(mode_req_ready), 0);

        // Release; the first post-release cycle follows the 2-stage synchroniser
        rst_n = 1'b1;
        sb.push_back(4'd4);
        cyc(2);
        count_state(S_FLUSH, 100, n);
        check("init_flush_len", n, 16);
        check("acq_rx_flush", int'(rx_flush), 0);
        check("acq_ready", int'(mode_req_ready), 1);
        check("acq_txen", int'(tx_enable), 1);
        wait_link(200, n);
        check("init_lock_cycles", n, 32);
        check("locked_state", int'(state_dbg), S_LOCKED);
        sb_pop("init_mode");

        // Mode change to 2, tlast ten cycles after the request
        check("lk_ready", int'(mode_req_ready), 1);
        tx_data_tvalid = 1'b1;
        request(4'd2);
        sb.push_back(4'd2);
        check("req_ready_drop", int'(mode_req_ready), 0);
        check("drain_state", int'(state_dbg), S_DRAIN);
        check("drain_linkup", int'(link_up), 0);
        cyc(9);
        check("drain_txen", int'(tx_enable), 1);
        tx_data_tlast = 1'b1;
        cyc(1);
        tx_data_tlast  = 1'b0;
        tx_data_tvalid = 1'b0;
        check("tlast_txen", int'(tx_enable), 0);
        check("apply_state", int'(state_dbg), S_APPLY);
        cyc(1);
        check("post_apply_txen", int'(tx_enable), 1);
        check("post_apply_mode", int'(MODE_CTRL), 2);
        count_state(S_FLUSH, 100, n);
        check("mode2_flush_len", n, 16);
        wait_link(200, n);
        check("mode2_lock_cycles", n, 32);
        sb_pop("mode2");

        // Loss boundary: 63 low cycles keep the link, 64 drop it
        rx_valid = 1'b0;
        cyc(63);
        rx_valid = 1'b1;
        check("loss63_linkup", int'(link_up), 1);
        cyc(3);
        check("loss63_state", int'(state_dbg), S_LOCKED);
        rx_valid = 1'b0;
        cyc(63);
        check("loss63b_linkup", int'(link_up), 1);
        cyc(1);
        rx_valid = 1'b1;
        check("loss64_linkup", int'(link_up), 0);
        check("loss64_state", int'(state_dbg), S_FLUSH);
        check("loss64_flush", int'(rx_flush), 1);
        sb.push_back(4'd2);
        wait_link(200, n);
        check("relock_cycles", n, 48);
        sb_pop("relock_mode");

        // Same-mode request in LOCKED is consumed silently
        request(4'd2);
        check("same_ready_drop", int'(mode_req_ready), 0);
        check("same_state", int'(state_dbg), S_LOCKED);
        check("same_linkup", int'(link_up), 1);
        cyc(1);
        check("same_ready_back", int'(mode_req_ready), 1);
        cyc(20);
        check("same_no_flush", int'(rx_flush), 0);
        check("same_mode", int'(MODE_CTRL), 2);

        // Drain timeout: no tlast ever arrives
        request(4'd7);
        sb.push_back(4'd7);
        count_state(S_DRAIN, 2000, n);
        check("drain_timeout_len", n, 1024);
        check("drain_to_txen", int'(tx_enable), 0);
        check("drain_to_state", int'(state_dbg), S_APPLY);
        cyc(1);
        check("drain_to_mode", int'(MODE_CTRL), 7);
        wait_link(200, n);
        check("mode7_lock_cycles", n, 48);
        sb_pop("mode7");

        // Lock timeouts down to FAIL
        rx_valid = 1'b0;
        count_state(S_LOCKED, 100, n);
        check("pre_retry_loss", n, 64);
        for (int a = 1; a <= 3; a++) begin
            count_state(S_FLUSH, 100, n);
            check($sformatf("retry%0d_flush_len", a), n, 16);
            count_state(S_ACQ, 5000, n);
            check($sformatf("retry%0d_acq_len", a), n, 4096);
            if (a < 3) begin
                check($sformatf("retry%0d_state", a), int'(state_dbg), S_FLUSH);
                check($sformatf("retry%0d_fail", a), int'(link_fail), 0);
            end
        end
        check("fail_state", int'(state_dbg), S_FAIL);
        check("fail_flag", int'(link_fail), 1);
        check("fail_txen", int'(tx_enable), 1);
        check("fail_rxflush", int'(rx_flush), 0);
        check("fail_ready", int'(mode_req_ready), 1);
        cyc(10);
        check("fail_hold", int'(link_fail), 1);
        rx_valid = 1'b1;
        request(4'd4);
        sb.push_back(4'd4);
        check("fail_clear", int'(link_fail), 0);
        check("fail_to_drain", int'(state_dbg), S_DRAIN);
        tx_data_tvalid = 1'b1;
        tx_data_tlast  = 1'b1;
        cyc(1);
        tx_data_tvalid = 1'b0;
        tx_data_tlast  = 1'b0;
        wait_link(200, n);
        check("recover_lock_cycles", n, 49);
        sb_pop("recover_mode");

        // Reset in the middle of DRAIN; the pending request is discarded
        request(4'd9);
        cyc(5);
        check("mid_drain_state", int'(state_dbg), S_DRAIN);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_state", int'(state_dbg), S_FLUSH);
        check("async_mode", int'(MODE_CTRL), 4);
        check("async_flush", int'(rx_flush), 1);
        check("async_txen", int'(tx_enable), 0);
        check("async_linkup", int'(link_up), 0);
        check("async_ready", int'(mode_req_ready), 0);
        cyc(3);
        rst_n = 1'b1;
        sb.push_back(4'd4);
        cyc(2);
        wait_link(200, n);
        check("post_rst_lock_cycles", n, 48);
        sb_pop("post_rst_mode");
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
